// File: rtl/fifo_defs.sv
// Shared FIFO definitions: depth derivation, default thresholds and read-mode
// constants common to the sync and async FIFO families.
package fifo_defs;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_ADDR_WIDTH    = 4;
  localparam int DEF_AEMPTY_THRESH = 2;
  localparam int DEF_AFULL_MARGIN  = 2;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Push/pop, status and error bundle of the single-clock flagged FIFO; the
// fifo sits on the slave side, its producer/consumer on the master side.
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: synchronous write, asynchronous read (zero latency).
// No backpressure; contents are never reset.
module fifo_dpram
  import fifo_defs::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [depth_of(ADDR_WIDTH)];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with count, almost flags, sticky errors; read latency 1 (std) or 0 (FWFT).
// Backpressure via full/empty: writes while full and reads while empty are dropped and flagged.
module sync_fifo_flags
  import fifo_defs::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int FWFT          = MODE_STD,
  parameter int AFULL_THRESH  = depth_of(ADDR_WIDTH) - DEF_AFULL_MARGIN,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic             clk,
  input  logic             reset,
  sync_fifo_flags_if.slave f
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int CW    = ADDR_WIDTH + 1;

  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH >= AFULL_THRESH || AFULL_THRESH > DEPTH) begin : g_bad_thresh
    $error("sync_fifo_flags: illegal AFULL_THRESH/AEMPTY_THRESH");
  end
  if (FWFT != MODE_STD && FWFT != MODE_FWFT) begin : g_bad_mode
    $error("sync_fifo_flags: illegal FWFT mode");
  end

  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, cnt;
  logic [DATA_WIDTH-1:0] mem_rd;
  logic                  full, empty, wa, ra, ovf, udf;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign wa    = f.wr_en & ~full;
  assign ra    = f.rd_en & ~empty;

  fifo_dpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wa),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (f.wr_data),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (mem_rd)
  );

  // Pointers carry one extra bit and wrap modulo 2*DEPTH; count is kept separately.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wa) wr_ptr <= wr_ptr + 1'b1;
      if (ra) rd_ptr <= rd_ptr + 1'b1;
      case ({wa, ra})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      ovf <= (f.wr_en & full)  | (ovf & ~f.clr_err);
      udf <= (f.rd_en & empty) | (udf & ~f.clr_err);
    end
  end

  assign f.count        = cnt;
  assign f.full         = full;
  assign f.empty        = empty;
  assign f.almost_full  = (cnt >= CW'(AFULL_THRESH));
  assign f.almost_empty = (cnt <= CW'(AEMPTY_THRESH));
  assign f.overflow     = ovf;
  assign f.underflow    = udf;

  if (FWFT == MODE_FWFT) begin : g_fwft
    assign f.rd_data  = mem_rd;
    assign f.rd_valid = ~empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= ra;
        if (ra) rd_data_q <= mem_rd;
      end
    end

    assign f.rd_data  = rd_data_q;
    assign f.rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives a standard-read and an FWFT instance with identical stimulus and
// compares both against a queue-based reference model after every edge.
module tb_sync_fifo_flags;
  import fifo_defs::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFT   = 14;
  localparam int AET   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s_if ();
  sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) w_if ();

  sync_fifo_flags #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(MODE_STD),
    .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)
  ) u_std (.clk(clk), .reset(reset), .f(s_if));

  sync_fifo_flags #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(MODE_FWFT),
    .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)
  ) u_fwft (.clk(clk), .reset(reset), .f(w_if));

  int total = 0;
  int bad   = 0;

  // Reference model: stored words as a queue, plus sticky flags and std read register.
  logic [DW-1:0] q[$];
  bit            m_ovf, m_udf, m_vld;
  logic [DW-1:0] m_rdat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("s_count", 32'(s_if.count), n);
    chk("w_count", 32'(w_if.count), n);
    chk("s_full",  32'(s_if.full),  32'(n == DEPTH));
    chk("w_full",  32'(w_if.full),  32'(n == DEPTH));
    chk("s_empty", 32'(s_if.empty), 32'(n == 0));
    chk("w_empty", 32'(w_if.empty), 32'(n == 0));
    chk("s_afull", 32'(s_if.almost_full),  32'(n >= AFT));
    chk("w_afull", 32'(w_if.almost_full),  32'(n >= AFT));
    chk("s_aempty", 32'(s_if.almost_empty), 32'(n <= AET));
    chk("w_aempty", 32'(w_if.almost_empty), 32'(n <= AET));
    chk("s_ovf", 32'(s_if.overflow),  32'(m_ovf));
    chk("w_ovf", 32'(w_if.overflow),  32'(m_ovf));
    chk("s_udf", 32'(s_if.underflow), 32'(m_udf));
    chk("w_udf", 32'(w_if.underflow), 32'(m_udf));
    chk("s_rd_valid", 32'(s_if.rd_valid), 32'(m_vld));
    chk("s_rd_data",  32'(s_if.rd_data),  32'(m_rdat));
    chk("w_rd_valid", 32'(w_if.rd_valid), 32'(n != 0));
    if (n != 0) chk("w_rd_data", 32'(w_if.rd_data), 32'(q[0]));
  endtask

  task automatic step(input logic rst, input logic we, input logic [DW-1:0] wd,
                      input logic re, input logic ce);
    bit was_full, was_empty;
    reset     = rst;
    s_if.wr_en = we; s_if.wr_data = wd; s_if.rd_en = re; s_if.clr_err = ce;
    w_if.wr_en = we; w_if.wr_data = wd; w_if.rd_en = re; w_if.clr_err = ce;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_vld = 0; m_rdat = '0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_ovf = (we && was_full)  || (m_ovf && !ce);
      m_udf = (re && was_empty) || (m_udf && !ce);
      m_vld = re && !was_empty;
      if (m_vld) m_rdat = q.pop_front();
      if (we && !was_full) q.push_back(wd);
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [DW-1:0] d;
    m_rdat = '0;
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);

    // Fill 0x00..0x0F, then drain with rd_en held: count walks 0..16..0.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i), 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);

    // Underflow, clear, refill, overflow with 0xAA, clear, set+clear together.
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(8'h30 + i), 0, 0);
    step(0, 1, 8'hAA, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 1);
    step(0, 1, 8'hAA, 0, 1);
    step(0, 0, 8'h00, 0, 1);

    // Simultaneous access at full, at 5, and at empty.
    step(0, 1, 8'hBB, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 1, 0);
    step(0, 1, 8'hC5, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 1);
    step(0, 1, 8'hD0, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 1);

    // FWFT sequence: 0x55 then 0x22 into an empty FIFO, pop twice.
    step(0, 1, 8'h55, 0, 0);
    step(0, 1, 8'h22, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);

    // Reset mid-operation, then a single write must land at address 0.
    for (int i = 0; i < 7; i++) step(0, 1, 8'(8'h60 + i), 0, 0);
    step(1, 0, 8'h00, 0, 0);
    step(0, 1, 8'h77, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);

    // Streaming 40 words at a steady count of 3 across pointer wrap.
    for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom), 0, 0);
    for (int i = 0; i < 40; i++) step(0, 1, 8'($urandom), 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0);

    // Random traffic with occasional error clears.
    for (int i = 0; i < 400; i++) begin
      d = 8'($urandom);
      step(0, 1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parametrised single-clock FIFO. It is the same-clock-domain successor to the team's async FIFO.
- Adds a fill-level count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode.
- Used as an elastic buffer between same-clock pipeline stages and as the read/write-side buffer next to the async FIFO.

Parameters:
- DATA_WIDTH, 8, width of each stored word
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH entries
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through
- AFULL_THRESH, DEPTH-2, almost_full asserts when count >= this value
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this value

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- rd_en  in  1  read request (in FWFT mode: pop)
- clr_err  in  1  clears the sticky error flags
- rd_data  out  DATA_WIDTH  read word
- rd_valid  out  1  rd_data is valid
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_THRESH
- almost_empty  out  1  count <= AEMPTY_THRESH
- count  out  ADDR_WIDTH+1  current number of stored words
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset (clk edge with reset=1):
  - wr_ptr, rd_ptr and count return to 0; rd_data=0; rd_valid=0; overflow=0; underflow=0.
  - Therefore empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are not cleared. Reset mid-operation discards all stored words; the first write after reset lands at address 0.
- Pointers are ADDR_WIDTH+1 bits wide. The address is the low ADDR_WIDTH bits, and pointers wrap naturally modulo 2*DEPTH.
- Write accepted (wa) = wr_en & ~full. On wa: mem[wr_ptr] <= wr_data and wr_ptr+1.
- Read accepted (ra) = rd_en & ~empty. On ra: rd_ptr+1.
- full and empty are evaluated on the registered pre-edge state.
  - Full with wr_en and rd_en both high: the read is accepted; the write is rejected and flagged as overflow.
  - Empty with both high: the write is accepted; the read is rejected and flagged as underflow. This applies in both read modes.
- count update: +1 when wa only; -1 when ra only; unchanged when both or neither. count never leaves 0..DEPTH.
- full, empty, almost_full and almost_empty are combinational decodes of registered count. They reflect the state after each edge, with no extra latency.
- overflow sets on wr_en & full; underflow sets on rd_en & empty. Both hold until clr_err. If set and clr_err occur in the same cycle, set wins.
- FWFT=0 read mode:
  - On ra, rd_data <= mem[rd_ptr] and rd_valid <= 1, so data appears one cycle after rd_en.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
- FWFT=1 read mode:
  - rd_data = mem[rd_ptr] combinationally; rd_valid = ~empty.
  - rd_en acts as an acknowledge/pop, and the next word is visible in the cycle after the pop.
  - A word written into an empty FIFO is visible on rd_data the cycle after the write edge.
- Throughput: one write and one read per cycle sustained, with no bubbles at pointer wrap-around.
- Threshold legality: 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH. Any other setting is a parameter error, and elaboration must fail via a generate-time check.

Decomposition:
- Shared package/header fifo_defs holds:
  - the DEPTH derivation function (2**ADDR_WIDTH);
  - default threshold localparams;
  - the FWFT mode constants MODE_STD=0 and MODE_FWFT=1, also reused by the async FIFO.
- One sub-module, fifo_dpram: simple dual-port RAM with one synchronous write port and one asynchronous read port.
  - The controller (pointers, count, flags, read mode) stays in sync_fifo_flags.
  - The sub-module is interchangeable with a registered-read RAM for FWFT=0.

Test Plan:
- Fill/drain (DEPTH=16, FWFT=0):
  - Stimulus: write 0x00..0x0F on 16 back-to-back cycles, then hold rd_en for 16 cycles.
  - Response: full=1 with count=16 after the 16th write; rd_data returns 0x00..0x0F in order, each one cycle after its rd_en; empty=1 with count=0 at the end.
- Thresholds (AFULL=14, AEMPTY=2):
  - Stimulus: step count through 0..16, then back down.
  - Response: almost_empty=1 for count<=2; almost_full=1 for count>=14; both flags correct in each direction.
- Overflow/underflow:
  - Stimulus: write 0xAA while full; read while empty; pulse clr_err; pulse clr_err again in the same cycle as a new overflow.
  - Response: count and contents unchanged by the rejected accesses; each flag sticky until clr_err; flag remains 1 in the simultaneous set+clear case.
- Simultaneous access:
  - Stimulus: wr_en=rd_en=1 at count=0, at count=16 and at count=5.
  - Response: count goes 0->1 (underflow=1); 16->15 (overflow=1); 5->5.
- FWFT=1:
  - Stimulus: write 0x55 into an empty FIFO, then 0x22; pop twice.
  - Response: rd_data=0x55 with rd_valid=1 the cycle after the first write; 0x22 visible the cycle after the first pop; rd_valid=0 after the second pop.
- Reset mid-operation and wrap-around:
  - Stimulus: write 7 words, assert reset for one cycle, then write 0x77.
  - Response: count=1; 0x77 is read back from address 0.
  - Stimulus: continuous streaming of 40 words with count held at 3.
  - Response: the pointers wrap correctly and no data is lost.
